// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional busy-wait timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TX_BUSY_BIT    = 0,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 ctl_reg_we,
    output logic [18:0]          ctl_reg_wdata,
    output logic [18:0]          ctl_reg_wmask,
    input  logic [11:0]          st_reg_rdata,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {StIdle, StWrite, StSettle, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] grant_id_q;
    logic [7:0]      data_q;
    logic [3:0]      settle_cnt_q, settle_cnt_d;
    logic [ID_W-1:0] winner;
    logic [7:0]      sel_byte;
    logic            found;
    logic            grant;
    logic            tx_busy;
    logic            tmo_hit;

    assign tx_busy = st_reg_rdata[TX_BUSY_BIT];

    // First valid requester searching upward from rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        found    = 1'b0;
        winner   = '0;
        sel_byte = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = ID_W'(cand);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) sel_byte = req_data[8*i +: 8];
        end
    end

    assign grant     = (state_q == StIdle) && found;
    // Gated by arst so the strobe is low while reset is held.
    assign req_ready = (grant && !arst) ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant) state_d = StWrite;
            end
            StWrite: begin
                settle_cnt_d = '0;
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) begin
                    state_d = StWaitDone;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy || tmo_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            data_q       <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            if (grant) begin
                rr_ptr_q   <= ID_W'((32'(winner) + 1) % NUM_REQ);
                grant_id_q <= winner;
                data_q     <= sel_byte;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Counter is zero on the first WAIT_DONE cycle and counts WAIT_DONE cycles.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StSettle) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StWaitDone) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign tmo_hit     = (state_q == StWaitDone) && tx_busy && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
    assign timeout_err = tmo_hit;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    logic unused_status;
    assign unused_status = ^st_reg_rdata;

    assign grant_id      = grant_id_q;
    assign busy          = (state_q != StIdle);
    assign ctl_reg_we    = (state_q == StWrite);
    assign ctl_reg_wdata = ctl_reg_we ? {data_q, 1'b1, 10'h0} : '0;
    assign ctl_reg_wmask = ctl_reg_we ? {8'hFF, 1'b1, 10'h0} : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, hold-off, reset in WRITE,
// fairness, withdrawn request and busy-wait timeout (both macro settings).
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int S  = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO  = 50;
    localparam int HOLD = 40;
`else
    localparam int TMO  = 65535;
    localparam int HOLD = 100;
`endif

    logic          clk = 1'b0;
    logic          arst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [1:0]    grant_id;
    logic          ctl_reg_we;
    logic [18:0]   ctl_reg_wdata;
    logic [18:0]   ctl_reg_wmask;
    logic [11:0]   st;
    logic          busy;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .TX_BUSY_BIT   (0),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .ctl_reg_we   (ctl_reg_we),
        .ctl_reg_wdata(ctl_reg_wdata),
        .ctl_reg_wmask(ctl_reg_wmask),
        .st_reg_rdata (st),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_reset;
        arst = 1'b1;
        req_valid = '1;
        repeat (2) tick();
        n_tests++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_tests++;
        if (ctl_reg_we !== 1'b0 || ctl_reg_wdata !== 19'h0 || ctl_reg_wmask !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_ctl: we=%b wdata=%h wmask=%h want 0/0/0", ctl_reg_we, ctl_reg_wdata, ctl_reg_wmask);
        end
        n_tests++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b tmo=%b gid=%0d want 0/0/0", busy, timeout_err, grant_id);
        end
        req_valid = '0;
        arst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int cyc = 1;
        int extra_we = 0;
        st = '0;
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_tests++;
        if (ctl_reg_we !== 1'b1 || ctl_reg_wdata !== 19'h52C00 || ctl_reg_wmask !== 19'h7FC00) begin
            n_fail++;
            $display("FAIL single_write: we=%b wdata=%h wmask=%h want 1/52c00/7fc00", ctl_reg_we, ctl_reg_wdata, ctl_reg_wmask);
        end
        n_tests++;
        if (grant_id !== 2'd2 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL single_gid: gid=%0d ready=%b want 2/0000", grant_id, req_ready);
        end
        while (busy && cyc < 50) begin
            tick();
            cyc++;
            if (ctl_reg_we) extra_we++;
        end
        n_tests++;
        if (cyc !== 3 + S || extra_we !== 0) begin
            n_fail++;
            $display("FAIL single_spacing: idle after %0d cycles (extra we %0d) want %0d (0)", cyc, extra_we, 3 + S);
        end
    endtask

    task automatic test_busy_holdoff;
        int viol = 0;
        req_data = {8'h44, 8'h77, 8'h3C, 8'h11};
        req_valid = 4'b0010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL holdoff_ready: got %b want 0010", req_ready); end
        tick();
        st[0] = 1'b1;
        req_valid = 4'b0011;
        #1;
        n_tests++;
        if (ctl_reg_we !== 1'b1 || ctl_reg_wdata !== 19'h1E400) begin
            n_fail++;
            $display("FAIL holdoff_write: we=%b wdata=%h want 1/1e400", ctl_reg_we, ctl_reg_wdata);
        end
        for (int i = 0; i < HOLD; i++) begin
            tick();
            if (ctl_reg_we || req_ready !== 4'b0 || !busy) viol++;
        end
        st[0] = 1'b0;
        #1;
        n_tests++;
        if (viol !== 0 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL holdoff_quiet: violations=%0d ready=%b want 0/0000", viol, req_ready);
        end
        tick();
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL holdoff_regrant: got %b want 0001", req_ready); end
        tick();
        n_tests++;
        if (ctl_reg_we !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL holdoff_we: we=%b gid=%0d want 1/0", ctl_reg_we, grant_id);
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid_write;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        n_tests++;
        if (ctl_reg_we !== 1'b1 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL midrst_pre: we=%b gid=%0d want 1/2", ctl_reg_we, grant_id);
        end
        arst = 1'b1;
        #1;
        n_tests++;
        if (ctl_reg_we !== 1'b0 || ctl_reg_wdata !== 19'h0 || ctl_reg_wmask !== 19'h0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_drop: we=%b wdata=%h wmask=%h busy=%b gid=%0d want all 0",
                     ctl_reg_we, ctl_reg_wdata, ctl_reg_wmask, busy, grant_id);
        end
        tick();
        arst = 1'b0;
        req_valid = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_tests++;
        if (grant_id !== 2'd0 || ctl_reg_wdata !== 19'h08C00) begin
            n_fail++;
            $display("FAIL midrst_data: gid=%0d wdata=%h want 0/08c00", grant_id, ctl_reg_wdata);
        end
        wait_idle();
    endtask

    task automatic test_fairness;
        int k = 0;
        int bcnt = 0;
        int viol = 0;
        logic [7:0] exp_byte;
        arst = 1'b1;
        tick();
        arst = 1'b0;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_valid = 4'hF;
        for (int cyc = 0; cyc < 600 && k < 6; cyc++) begin
            #1;
            if (bcnt != 0 && req_ready !== 4'b0) viol++;
            if (ctl_reg_we) begin
                exp_byte = 8'hA0 + 8'(((k - 1) % 4) * 8'h11);
                n_tests++;
                if (ctl_reg_wdata[18:11] !== exp_byte) begin
                    n_fail++;
                    $display("FAIL fair_data%0d: got %h want %h", k - 1, ctl_reg_wdata[18:11], exp_byte);
                end
                bcnt = 20;
            end
            if (req_ready !== 4'b0) begin
                n_tests++;
                if (req_ready !== (4'b0001 << (k % 4))) begin
                    n_fail++;
                    $display("FAIL fair_order%0d: got %b want %b", k, req_ready, 4'b0001 << (k % 4));
                end
                k++;
            end
            st[0] = (bcnt != 0);
            if (bcnt != 0) bcnt--;
            tick();
        end
        n_tests++;
        if (k !== 6 || viol !== 0) begin
            n_fail++;
            $display("FAIL fair_total: grants=%0d ready_while_busy=%0d want 6/0", k, viol);
        end
        req_valid = '0;
        st = '0;
        wait_idle();
    endtask

    task automatic test_withdrawn;
        int viol = 0;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        st[0] = 1'b1;
        repeat (8) tick();
        req_valid = 4'b0010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_waiting: ready=%b busy=%b want 0000/1", req_ready, busy);
        end
        tick();
        req_valid = '0;
        repeat (5) tick();
        st[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ctl_reg_we || req_ready !== 4'b0) viol++;
        end
        n_tests++;
        if (viol !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_nogrant: violations=%0d busy=%b want 0/0", viol, busy);
        end
    endtask

    task automatic test_timeout;
        int pulses = 0;
        int first = -1;
        logic busy_at = 1'bx;
        logic busy_after = 1'bx;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        st[0] = 1'b1;
        repeat (1 + S) tick();
        for (int i = 0; i < 80; i++) begin
            if (first >= 0 && i == first + 1) busy_after = busy;
            if (timeout_err === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    busy_at = busy;
                end
            end
            tick();
        end
`ifdef UART_ARB_TIMEOUT_EN
        n_tests++;
        if (pulses !== 1 || first !== TMO) begin
            n_fail++;
            $display("FAIL tmo_pulse: pulses=%0d at=%0d want 1 at %0d", pulses, first, TMO);
        end
        n_tests++;
        if (busy_at !== 1'b1 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_busy: busy at pulse=%b after=%b want 1/0", busy_at, busy_after);
        end
`else
        n_tests++;
        if (pulses !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_off: pulses=%0d busy=%b want 0/1", pulses, busy);
        end
`endif
        st[0] = 1'b0;
        wait_idle();
    endtask

    initial begin
        arst = 1'b1;
        req_valid = '0;
        req_data = '0;
        st = '0;
        test_reset();
        test_single();
        test_busy_holdoff();
        test_reset_mid_write();
        test_fairness();
        test_withdrawn();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the UART IP transmitter between `NUM_REQ` byte-producing requesters. It accepts one byte per grant over a valid/ready handshake and issues a single masked write to the UART control register (data field plus TX-enable bit). It then holds off further grants until the UART status register reports the transmitter idle. It sits between on-chip byte sources and the UART IP's `ctl_reg_*` / `st_reg_*` ports.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `TX_BUSY_BIT`, 0: index of the TX-busy flag in `st_reg_rdata`.
- `SETTLE_CYCLES`, 4: cycles to wait after the write before sampling busy (1..15).
- `TIMEOUT_CYCLES`, 65535: busy-wait limit; used only with the macro (16-bit counter).

Ports:
- `clk` in 1: single clock, rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a byte.
- `req_data` in 8*NUM_REQ: byte of requester i at `[8i+7:8i]`.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `grant_id` out $clog2(NUM_REQ): last accepted requester.
- `ctl_reg_we` out 1: UART control register write strobe.
- `ctl_reg_wdata` out 19: `{data[7:0], 1'b1, 10'h0}`.
- `ctl_reg_wmask` out 19: `{8'hFF, 1'b1, 10'h0}` during the write, else 0.
- `st_reg_rdata` in 12: UART status register.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse on busy-wait timeout.

## Operation
- States:
  - IDLE → WRITE → SETTLE → WAIT_DONE → IDLE.
- IDLE:
  - If any `req_valid` is set, the winner is the first set bit searching upward from `rr_ptr`, wrapping.
  - `req_ready[winner]` asserts combinationally in the same cycle, so the handshake completes at that edge.
  - The byte is latched, `grant_id` ← winner, `rr_ptr` ← (winner+1) mod NUM_REQ, next state WRITE.
- WRITE (exactly 1 cycle):
  - `ctl_reg_we` = 1 with the wdata/wmask above.
  - Only bits [18:10] are written, so baud, stop, parity, frame and on fields are untouched.
- SETTLE:
  - A 4-bit counter runs for `SETTLE_CYCLES` cycles, then the state moves to WAIT_DONE.
- WAIT_DONE:
  - Stays until `st_reg_rdata[TX_BUSY_BIT]`==0, then goes to IDLE.
- `req_ready` is 0 in every state except IDLE.
- No request is lost: a requester holding `req_valid` is served within NUM_REQ grants.
- A requester that drops `req_valid` before being granted transfers nothing; this is legal.
- `req_data` of a non-granted requester is don't-care.
- Outputs other than strobes are registered.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `grant_id`=0, latched byte 0.
  - `ctl_reg_we`=0, `ctl_reg_wdata`=0, `ctl_reg_wmask`=0.
  - `busy`=0, `timeout_err`=0, `req_ready`=0.
- Latency: handshake at edge N; `ctl_reg_we` high for cycle N+1 only.
- Busy is first sampled at cycle N+2+SETTLE_CYCLES.
- Minimum grant spacing is 3+SETTLE_CYCLES cycles when the UART reports not-busy immediately.
- Busy already low at the end of SETTLE: IDLE the next cycle, and a new grant is possible in that IDLE cycle.
- `arst` asserted mid-operation, including during WRITE:
  - All outputs drop immediately to their reset values.
  - The latched byte is discarded.
  - `rr_ptr` returns to 0.
- All requesters valid continuously: grants go 0,1,2,3,0,…

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter, cleared on entry to WAIT_DONE, increments each WAIT_DONE cycle.
  - When it reaches `TIMEOUT_CYCLES` with busy still high, `timeout_err` pulses for 1 cycle and the state returns to IDLE.
- Not defined:
  - WAIT_DONE waits indefinitely.
  - `timeout_err` is tied to 0, and no counter logic is synthesized.

## Test plan
- Single request: requester 2 presents 0xA5 with status busy=0 → `req_ready`=0b0100 for 1 cycle; next cycle `ctl_reg_we`=1, wdata=0x52C00, wmask=0x7FC00; `grant_id`=2.
- Fairness: all 4 valid continuously, UART busy for 20 cycles per byte → grant order 0,1,2,3,0,1; no `req_ready` while busy.
- Busy hold-off: busy held high for 100 cycles after the write → no `ctl_reg_we`/`req_ready` until 1 cycle after busy falls.
- Reset mid-WRITE: assert `arst` during the WE cycle → `ctl_reg_we` drops the same cycle; after release the first grant goes to requester 0.
- Timeout (macro on, TIMEOUT_CYCLES=50): busy stuck high → `timeout_err` pulses exactly once, 50 cycles into WAIT_DONE; `busy`→0 next cycle. Macro off: `busy` stays 1 and `timeout_err` stays 0.
- Withdrawn request: requester 1 valid for 1 cycle while the arbiter is in WAIT_DONE, then drops → no grant to requester 1 and no UART write.
